// File: rtl/picoblaze_io_pkg.sv
// Shared address map and register bit positions for the PicoBlaze I/O controller.
package picoblaze_io_pkg;

    localparam logic [7:0] ADDR_IN_BASE    = 8'h00;
    localparam logic [7:0] ADDR_OUT_BASE   = 8'h80;
    localparam logic [7:0] ADDR_CTRL       = 8'hF0;
    localparam logic [7:0] ADDR_STATUS     = 8'hF1;
    localparam logic [7:0] ADDR_TICK_COUNT = 8'hF2;

    localparam int unsigned CTRL_TIMER_EN = 0;
    localparam int unsigned CTRL_TICK_IE  = 1;
    localparam int unsigned CTRL_EXT_IE   = 2;

    localparam int unsigned STAT_TICK_PEND = 0;
    localparam int unsigned STAT_EXT_PEND  = 1;

endpackage

// File: rtl/pb_tick_timer.sv
// Free-running prescaler producing a one-cycle tick every TERM_COUNT+1 clocks
// while enabled, plus an 8-bit wrapping count of ticks.
module pb_tick_timer #(
    parameter int unsigned TERM_COUNT = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       en,
    output logic       tick,
    output logic [7:0] tick_count
);

    localparam int unsigned CntW = $clog2(TERM_COUNT + 1);

    logic [CntW-1:0] presc_q;
    logic            tick_q;
    logic [7:0]      count_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_q <= '0;
            tick_q  <= 1'b0;
            count_q <= 8'h00;
        end else if (!en) begin
            // Count holds while disabled; only the prescaler is cleared.
            presc_q <= '0;
            tick_q  <= 1'b0;
        end else if (presc_q == CntW'(TERM_COUNT)) begin
            presc_q <= '0;
            tick_q  <= 1'b1;
            count_q <= count_q + 8'h01;
        end else begin
            presc_q <= presc_q + 1'b1;
            tick_q  <= 1'b0;
        end
    end

    assign tick       = tick_q;
    assign tick_count = count_q;

endmodule

// File: rtl/picoblaze_io_ctrl.sv
// PicoBlaze port-space I/O and interrupt controller: decoded in/out banks,
// tick timer, synchronised external event and interrupt request latch.
module picoblaze_io_ctrl
    import picoblaze_io_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 25000000,
    parameter int unsigned TICK_HZ     = 1,
    parameter int unsigned NUM_IN      = 4,
    parameter int unsigned NUM_OUT     = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [7:0]           port_id,
    input  logic [7:0]           out_port,
    input  logic                 write_strobe,
    input  logic                 read_strobe,
    output logic [7:0]           in_port,
    output logic                 interrupt,
    input  logic                 interrupt_ack,
    input  logic [8*NUM_IN-1:0]  input_data,
    output logic [8*NUM_OUT-1:0] output_data,
    input  logic                 ext_event
);

    localparam int unsigned Div       = CLK_FREQ_HZ / TICK_HZ;
    localparam int unsigned TermCount = (Div > 1) ? Div - 1 : 1;

    logic [NUM_OUT-1:0][7:0] out_q;
    logic [2:0]              ctrl_q, ctrl_d;
    logic [1:0]              pend_q, pend_d, pend_prev_q;
    logic [2:0]              sync_q;
    logic                    irq_q, irq_d;
    logic [7:0]              in_port_q, rd_data;
    logic                    tick;
    logic [7:0]              tick_count;

    logic       ctrl_wr, stat_wr, ext_rise, irq_set;
    logic [1:0] set_evt, w1c, ie, ie_rise, pend_rise;

    // Reads have no side effects, so the strobe is not needed for decode.
    logic unused_read_strobe;
    assign unused_read_strobe = read_strobe;

    pb_tick_timer #(
        .TERM_COUNT(TermCount)
    ) u_timer (
        .clk       (clk),
        .reset_n   (reset_n),
        .en        (ctrl_q[CTRL_TIMER_EN]),
        .tick      (tick),
        .tick_count(tick_count)
    );

    always_comb begin
        ctrl_wr  = write_strobe && (port_id == ADDR_CTRL);
        stat_wr  = write_strobe && (port_id == ADDR_STATUS);
        ext_rise = sync_q[1] & ~sync_q[2];

        set_evt                 = 2'b00;
        set_evt[STAT_TICK_PEND] = tick;
        set_evt[STAT_EXT_PEND]  = ext_rise;
        w1c    = stat_wr ? out_port[1:0] : 2'b00;
        pend_d = (pend_q & ~w1c) | set_evt;
        ctrl_d = ctrl_wr ? out_port[2:0] : ctrl_q;

        ie                 = 2'b00;
        ie[STAT_TICK_PEND] = ctrl_q[CTRL_TICK_IE];
        ie[STAT_EXT_PEND]  = ctrl_q[CTRL_EXT_IE];
        ie_rise = 2'b00;
        if (ctrl_wr) begin
            ie_rise[STAT_TICK_PEND] = out_port[CTRL_TICK_IE] & ~ie[STAT_TICK_PEND];
            ie_rise[STAT_EXT_PEND]  = out_port[CTRL_EXT_IE] & ~ie[STAT_EXT_PEND];
        end
        pend_rise = pend_q & ~pend_prev_q;
        irq_set   = |((pend_rise & ie) | (ie_rise & pend_q));
        irq_d     = irq_set | (irq_q & ~interrupt_ack);
    end

    always_comb begin
        rd_data = 8'h00;
        for (int unsigned k = 0; k < NUM_IN; k++) begin
            if (port_id == ADDR_IN_BASE + 8'(k)) rd_data = input_data[8*k +: 8];
        end
        for (int unsigned k = 0; k < NUM_OUT; k++) begin
            if (port_id == ADDR_OUT_BASE + 8'(k)) rd_data = out_q[k];
        end
        if (port_id == ADDR_CTRL)       rd_data = {5'b0, ctrl_q};
        if (port_id == ADDR_STATUS)     rd_data = {6'b0, pend_q};
        if (port_id == ADDR_TICK_COUNT) rd_data = tick_count;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_q       <= '0;
            ctrl_q      <= 3'b000;
            pend_q      <= 2'b00;
            pend_prev_q <= 2'b00;
            sync_q      <= 3'b000;
            irq_q       <= 1'b0;
            in_port_q   <= 8'h00;
        end else begin
            for (int unsigned k = 0; k < NUM_OUT; k++) begin
                if (write_strobe && (port_id == ADDR_OUT_BASE + 8'(k))) out_q[k] <= out_port;
            end
            ctrl_q      <= ctrl_d;
            pend_q      <= pend_d;
            pend_prev_q <= pend_q;
            sync_q      <= {sync_q[1:0], ext_event};
            irq_q       <= irq_d;
            in_port_q   <= rd_data;
        end
    end

    assign in_port     = in_port_q;
    assign interrupt   = irq_q;
    assign output_data = out_q;

endmodule
